// File: rtl/boot_loader.sv
// Boot loader: copies BOOT_WORDS 32-bit boot ROM words into a 16-bit
// SRAM as low/high halfword pairs, then releases the processor reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   boot_en           sampled once in IDLE: 1 = copy, 0 = skip copy
//   boot_rom_rd_en    ROM read strobe; data returns one cycle later
//   boot_rom_addr     ROM word address (always tracks the word counter)
//   boot_rom_rd_data  ROM read data
//   sram_*            active-low SRAM controls, halfword address, write data
//   boot_busy         high while copying
//   boot_done         high once copy finished or skipped
//   proc_rst_n        processor reset release, equals boot_done
module boot_loader #(
    parameter int DATA_WIDTH      = 32,
    parameter int ROM_ADDR_WIDTH  = 10,
    parameter int SRAM_ADDR_WIDTH = 11,
    parameter int BOOT_WORDS      = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       boot_en,
    output logic                       boot_rom_rd_en,
    output logic [ROM_ADDR_WIDTH-1:0]  boot_rom_addr,
    input  logic [DATA_WIDTH-1:0]      boot_rom_rd_data,
    output logic                       sram_ce_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]                sram_wr_data,
    output logic                       boot_busy,
    output logic                       boot_done,
    output logic                       proc_rst_n
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WAIT_ROM = 3'd2;
    localparam logic [2:0] S_WR_LO    = 3'd3;
    localparam logic [2:0] S_WR_HI    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Terminal word index; comparing against it (rather than letting the
    // counter roll over) keeps a full-ROM copy from wrapping to word 0.
    localparam logic [ROM_ADDR_WIDTH-1:0] LAST_WORD =
        ROM_ADDR_WIDTH'(BOOT_WORDS - 1);

    logic [2:0]                state;
    logic [ROM_ADDR_WIDTH-1:0] wcnt;
    logic [DATA_WIDTH-1:0]     data_buf;

    logic wr_cyc;
    logic wr_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            data_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= boot_en ? S_READ : S_DONE;
                end
                S_READ: begin
                    state <= S_WAIT_ROM;
                end
                S_WAIT_ROM: begin
                    data_buf <= boot_rom_rd_data;
                    state    <= S_WR_LO;
                end
                S_WR_LO: begin
                    state <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (wcnt == LAST_WORD) begin
                        state <= S_DONE;
                    end else begin
                        wcnt  <= wcnt + 1'b1;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode from registered state only.
    assign wr_hi  = (state == S_WR_HI);
    assign wr_cyc = (state == S_WR_LO) || wr_hi;

    assign boot_rom_rd_en = (state == S_READ);
    assign boot_rom_addr  = wcnt;

    assign sram_ce_n = ~wr_cyc;
    assign sram_we_n = ~wr_cyc;
    assign sram_ub_n = ~wr_cyc;
    assign sram_lb_n = ~wr_cyc;
    assign sram_oe_n = 1'b1;
    assign sram_addr = {wcnt, wr_hi};

    always_comb begin
        sram_wr_data = '0;
        if (wr_hi) begin
            sram_wr_data = data_buf[DATA_WIDTH-1 -: 16];
        end else if (wr_cyc) begin
            sram_wr_data = data_buf[15:0];
        end
    end

    assign boot_busy  = (state == S_READ) || (state == S_WAIT_ROM) || wr_cyc;
    assign boot_done  = (state == S_DONE);
    assign proc_rst_n = boot_done;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a 4-word instance and a full 1024-word
// instance, each with its own ROM/SRAM models and protocol monitor.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- small instance (BOOT_WORDS=4) ----------------
    logic        rst_n   = 1'b0;
    logic        boot_en = 1'b1;
    logic        rd_en;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q = '0;
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [10:0] s_addr;
    logic [15:0] s_wdata;
    logic        busy, done, prst_n;

    boot_loader #(
        .DATA_WIDTH(32), .ROM_ADDR_WIDTH(10),
        .SRAM_ADDR_WIDTH(11), .BOOT_WORDS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .boot_en(boot_en),
        .boot_rom_rd_en(rd_en), .boot_rom_addr(rom_addr),
        .boot_rom_rd_data(rom_q),
        .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n),
        .sram_addr(s_addr), .sram_wr_data(s_wdata),
        .boot_busy(busy), .boot_done(done), .proc_rst_n(prst_n)
    );

    logic [31:0] rom_s [0:3];
    logic [15:0] sram_s [0:7];
    int wr_cnt, rd_cnt, perr, exp_wa;

    initial begin
        rom_s[0] = 32'h11112222;
        rom_s[1] = 32'h33334444;
        rom_s[2] = 32'h55556666;
        rom_s[3] = 32'h77778888;
    end

    always @(posedge clk) if (rd_en) rom_q <= rom_s[rom_addr[1:0]];

    always @(negedge clk) begin
        if (!rst_n) exp_wa = 0;
        if (rd_en) rd_cnt++;
        if (!oe_n) perr++;
        if (busy && done) perr++;
        if (!ce_n) begin
            if (we_n || !oe_n || ub_n || lb_n) perr++;
            if (int'(s_addr) != exp_wa || s_addr > 11'd7) perr++;
            else sram_s[s_addr[2:0]] = s_wdata;
            exp_wa++;
            wr_cnt++;
        end
    end

    // ---------------- full instance (BOOT_WORDS=1024) ----------------
    logic        rst_n_f   = 1'b0;
    logic        boot_en_f = 1'b1;
    logic        rd_en_f;
    logic [9:0]  rom_addr_f;
    logic [31:0] rom_q_f = '0;
    logic        ce_n_f, we_n_f, oe_n_f, ub_n_f, lb_n_f;
    logic [10:0] s_addr_f;
    logic [15:0] s_wdata_f;
    logic        busy_f, done_f, prst_n_f;

    boot_loader #(
        .DATA_WIDTH(32), .ROM_ADDR_WIDTH(10),
        .SRAM_ADDR_WIDTH(11), .BOOT_WORDS(1024)
    ) dut_full (
        .clk(clk), .rst_n(rst_n_f), .boot_en(boot_en_f),
        .boot_rom_rd_en(rd_en_f), .boot_rom_addr(rom_addr_f),
        .boot_rom_rd_data(rom_q_f),
        .sram_ce_n(ce_n_f), .sram_we_n(we_n_f), .sram_oe_n(oe_n_f),
        .sram_ub_n(ub_n_f), .sram_lb_n(lb_n_f),
        .sram_addr(s_addr_f), .sram_wr_data(s_wdata_f),
        .boot_busy(busy_f), .boot_done(done_f), .proc_rst_n(prst_n_f)
    );

    logic [15:0] sram_f [0:2047];
    int wr_cnt_f, rd_cnt_f, perr_f, exp_wa_f, last_wa_f;

    // ROM word i = {i + 0x8000, i}.
    always @(posedge clk)
        if (rd_en_f) rom_q_f <= {16'(rom_addr_f) + 16'h8000, 16'(rom_addr_f)};

    always @(negedge clk) begin
        if (!rst_n_f) exp_wa_f = 0;
        if (rd_en_f) rd_cnt_f++;
        if (!oe_n_f) perr_f++;
        if (busy_f && done_f) perr_f++;
        if (!ce_n_f) begin
            if (we_n_f || !oe_n_f || ub_n_f || lb_n_f) perr_f++;
            if (int'(s_addr_f) != exp_wa_f) perr_f++;
            sram_f[s_addr_f] = s_wdata_f;
            last_wa_f = int'(s_addr_f);
            exp_wa_f++;
            wr_cnt_f++;
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_small();
        for (int i = 0; i < 8; i++) sram_s[i] = 16'hDEAD;
        wr_cnt = 0;
        rd_cnt = 0;
        perr   = 0;
    endtask

    // Release reset at a negedge and count rising edges until boot_done.
    task automatic run_to_done(output int edges);
        edges = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        boot_en = 1'b1;
        #3;
        n_cmp++;
        if (done !== 1'b0 || prst_n !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status got done=%b prst=%b busy=%b want 0 0 0",
                     done, prst_n, busy);
        end
        n_cmp++;
        if ({ce_n, we_n, oe_n, ub_n, lb_n} !== 5'b11111) begin
            n_fail++;
            $display("FAIL reset_sram_ctl got %b want 11111",
                     {ce_n, we_n, oe_n, ub_n, lb_n});
        end
        n_cmp++;
        if (rd_en !== 1'b0 || rom_addr !== 10'd0 || s_wdata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_rom got rd_en=%b addr=%0d wdata=%h want 0 0 0",
                     rd_en, rom_addr, s_wdata);
        end
    endtask

    task automatic check_image(input string tag);
        logic [15:0] exp [0:7];
        exp = '{16'h2222, 16'h1111, 16'h4444, 16'h3333,
                16'h6666, 16'h5555, 16'h8888, 16'h7777};
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (sram_s[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL %s_sram[%0d] got %h want %h",
                         tag, i, sram_s[i], exp[i]);
            end
        end
    endtask

    task automatic test_copy();
        int edges;
        rst_n = 1'b0;
        boot_en = 1'b1;
        clear_small();
        @(negedge clk);
        edges = 0;
        rst_n = 1'b1;
        @(posedge clk);
        edges++;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || rd_en !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL copy_first_read got busy=%b rd_en=%b done=%b want 1 1 0",
                     busy, rd_en, done);
        end
        boot_en = 1'b0;
        while (edges < 100 && !done) begin
            @(posedge clk);
            edges++;
            #1;
        end
        n_cmp++;
        if (edges != 17) begin
            n_fail++;
            $display("FAIL copy_latency got %0d edges want 17", edges);
        end
        n_cmp++;
        if (prst_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL copy_done_flags got prst=%b busy=%b want 1 0",
                     prst_n, busy);
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || rom_addr !== 10'd3) begin
            n_fail++;
            $display("FAIL copy_terminal got done=%b addr=%0d want 1 3",
                     done, rom_addr);
        end
        check_image("copy");
        n_cmp++;
        if (wr_cnt != 8 || rd_cnt != 4 || perr != 0) begin
            n_fail++;
            $display("FAIL copy_counts got wr=%0d rd=%0d perr=%0d want 8 4 0",
                     wr_cnt, rd_cnt, perr);
        end
    endtask

    task automatic test_skip();
        rst_n = 1'b0;
        boot_en = 1'b0;
        #3;
        clear_small();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || prst_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_done got done=%b prst=%b busy=%b want 1 1 0",
                     done, prst_n, busy);
        end
        boot_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_cnt != 0 || rd_cnt != 0 || perr != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL skip_idle got wr=%0d rd=%0d perr=%0d done=%b want 0 0 0 1",
                     wr_cnt, rd_cnt, perr, done);
        end
    endtask

    task automatic test_abort();
        int n, w0, edges;
        rst_n = 1'b0;
        boot_en = 1'b1;
        #3;
        clear_small();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(we_n === 1'b0 && s_addr === 11'd5) && n < 50);
        n_cmp++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL abort_reach_wr_hi got timeout after %0d cycles want addr 5", n);
        end
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ce_n, we_n, ub_n, lb_n} !== 4'b1111 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async got ctl=%b busy=%b want 1111 0",
                     {ce_n, we_n, ub_n, lb_n}, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_cnt != w0) begin
            n_fail++;
            $display("FAIL abort_no_write got %0d writes want %0d", wr_cnt, w0);
        end
        clear_small();
        run_to_done(edges);
        n_cmp++;
        if (edges != 17) begin
            n_fail++;
            $display("FAIL abort_restart_latency got %0d edges want 17", edges);
        end
        check_image("abort");
        n_cmp++;
        if (wr_cnt != 8 || rd_cnt != 4 || perr != 0) begin
            n_fail++;
            $display("FAIL abort_counts got wr=%0d rd=%0d perr=%0d want 8 4 0",
                     wr_cnt, rd_cnt, perr);
        end
    endtask

    task automatic test_full_rom();
        int edges;
        rst_n_f = 1'b0;
        boot_en_f = 1'b1;
        #3;
        wr_cnt_f = 0;
        rd_cnt_f = 0;
        perr_f = 0;
        last_wa_f = -1;
        @(negedge clk);
        rst_n_f = 1'b1;
        edges = 0;
        while (edges < 5000) begin
            @(posedge clk);
            edges++;
            #1;
            if (done_f) break;
        end
        n_cmp++;
        if (edges != 4097) begin
            n_fail++;
            $display("FAIL full_latency got %0d edges want 4097", edges);
        end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (done_f !== 1'b1 || busy_f !== 1'b0 || rom_addr_f !== 10'd1023) begin
            n_fail++;
            $display("FAIL full_no_wrap got done=%b busy=%b addr=%0d want 1 0 1023",
                     done_f, busy_f, rom_addr_f);
        end
        n_cmp++;
        if (wr_cnt_f != 2048 || rd_cnt_f != 1024 || perr_f != 0 || last_wa_f != 2047) begin
            n_fail++;
            $display("FAIL full_counts got wr=%0d rd=%0d perr=%0d last=%0d want 2048 1024 0 2047",
                     wr_cnt_f, rd_cnt_f, perr_f, last_wa_f);
        end
        n_cmp++;
        if (sram_f[0] !== 16'h0000 || sram_f[1] !== 16'h8000 ||
            sram_f[2046] !== 16'h03FF || sram_f[2047] !== 16'h83FF) begin
            n_fail++;
            $display("FAIL full_data got %h %h %h %h want 0000 8000 03ff 83ff",
                     sram_f[0], sram_f[1], sram_f[2046], sram_f[2047]);
        end
    endtask

    initial begin
        wr_cnt = 0; rd_cnt = 0; perr = 0; exp_wa = 0;
        wr_cnt_f = 0; rd_cnt_f = 0; perr_f = 0; exp_wa_f = 0; last_wa_f = -1;
        repeat (2) @(posedge clk);
        test_reset();
        test_copy();
        test_skip();
        test_abort();
        test_full_rom();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
